// File: rtl/pbus_bridge.sv
// pbus_bridge: single-outstanding bridge from the core data-bus master to the
// peripheral-bus interconnect master port. Each core request is registered,
// issued as a one-cycle p_req, then the bridge waits for the slave response.
// Decode faults and slave timeouts become error responses, and p_halt masks
// interconnect responses whenever no transfer is in flight.
module pbus_bridge #(
  parameter int  TIMEOUT     = 255,
  parameter int  XLEN        = 32,
  parameter int  BUS_WIDTH   = 32,
  parameter int  BUS_ACC_CNT = 4,
  localparam int ACC_W       = $clog2(BUS_ACC_CNT),
  localparam int CNT_W       = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  // core side
  input  logic                 s_req,
  input  logic [XLEN-1:0]      s_addr,
  input  logic                 s_w_rb,
  input  logic [ACC_W-1:0]     s_acc,
  input  logic [BUS_WIDTH-1:0] s_wdata,
  output logic                 s_ready,
  output logic                 s_resp,
  output logic [BUS_WIDTH-1:0] s_rdata,
  output logic                 s_err,
  output logic [1:0]           err_cause,
  output logic [XLEN-1:0]      err_addr,
  // interconnect side
  output logic                 p_req,
  output logic [XLEN-1:0]      p_addr,
  output logic                 p_w_rb,
  output logic [ACC_W-1:0]     p_acc,
  output logic [BUS_WIDTH-1:0] p_wdata,
  input  logic                 p_resp,
  input  logic [BUS_WIDTH-1:0] p_rdata,
  input  logic                 p_fault,
  output logic                 p_halt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [1:0]       CAUSE_DECODE  = 2'b01;
  localparam logic [1:0]       CAUSE_TIMEOUT = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(TIMEOUT - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 s_resp_q;
  logic                 s_err_q;
  logic [BUS_WIDTH-1:0] s_rdata_q;
  logic [1:0]           err_cause_q;
  logic [XLEN-1:0]      err_addr_q;
  logic [XLEN-1:0]      p_addr_q;
  logic                 p_w_rb_q;
  logic [ACC_W-1:0]     p_acc_q;
  logic [BUS_WIDTH-1:0] p_wdata_q;

  // Transfer FSM: request capture, issue, wait/timeout and registered response.
  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s_resp_q    <= 1'b0;
      s_err_q     <= 1'b0;
      s_rdata_q   <= '0;
      err_cause_q <= 2'b00;
      err_addr_q  <= '0;
      p_addr_q    <= '0;
      p_w_rb_q    <= 1'b0;
      p_acc_q     <= '0;
      p_wdata_q   <= '0;
    end else begin
      // Response strobes are single-cycle pulses unless re-armed below.
      s_resp_q <= 1'b0;
      s_err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // Stray p_resp here is ignored; only a core request moves us on.
          if (s_req) begin
            p_addr_q  <= s_addr;
            p_w_rb_q  <= s_w_rb;
            p_acc_q   <= s_acc;
            p_wdata_q <= s_wdata;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q <= '0;
          if (p_fault) begin
            s_resp_q    <= 1'b1;
            s_err_q     <= 1'b1;
            s_rdata_q   <= '0;
            err_cause_q <= CAUSE_DECODE;
            err_addr_q  <= p_addr_q;
            state_q     <= ST_IDLE;
          end else if (p_resp) begin
            s_resp_q  <= 1'b1;
            s_rdata_q <= p_rdata;
            state_q   <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A response landing on the last counted cycle still wins.
          if (p_resp) begin
            s_resp_q  <= 1'b1;
            s_rdata_q <= p_rdata;
            state_q   <= ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            s_resp_q    <= 1'b1;
            s_err_q     <= 1'b1;
            s_rdata_q   <= '0;
            err_cause_q <= CAUSE_TIMEOUT;
            err_addr_q  <= p_addr_q;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Status decoded straight from the state register; p_req lasts exactly
  // the single ISSUE cycle and the interconnect is halted whenever idle.
  assign s_ready   = (state_q == ST_IDLE);
  assign p_halt    = (state_q == ST_IDLE);
  assign p_req     = (state_q == ST_ISSUE);

  assign s_resp    = s_resp_q;
  assign s_err     = s_err_q;
  assign s_rdata   = s_rdata_q;
  assign err_cause = err_cause_q;
  assign err_addr  = err_addr_q;
  assign p_addr    = p_addr_q;
  assign p_w_rb    = p_w_rb_q;
  assign p_acc     = p_acc_q;
  assign p_wdata   = p_wdata_q;

endmodule

// File: tb/tb_pbus_bridge.sv
// Directed testbench for pbus_bridge with TIMEOUT=8: read with a slow slave,
// decode fault, timeout with late response, response on the last counted
// cycle, back-to-back request, request while busy and reset mid-transfer.
`timescale 1ns/1ps
module tb_pbus_bridge;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_w_rb;
  logic [1:0]  s_acc;
  logic [31:0] s_wdata;
  logic        s_ready;
  logic        s_resp;
  logic [31:0] s_rdata;
  logic        s_err;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;
  logic        p_req;
  logic [31:0] p_addr;
  logic        p_w_rb;
  logic [1:0]  p_acc;
  logic [31:0] p_wdata;
  logic        p_resp;
  logic [31:0] p_rdata;
  logic        p_fault;
  logic        p_halt;

  int n_cmp = 0;
  int n_err = 0;

  pbus_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc),
    .s_wdata(s_wdata), .s_ready(s_ready), .s_resp(s_resp), .s_rdata(s_rdata),
    .s_err(s_err), .err_cause(err_cause), .err_addr(err_addr),
    .p_req(p_req), .p_addr(p_addr), .p_w_rb(p_w_rb), .p_acc(p_acc),
    .p_wdata(p_wdata), .p_resp(p_resp), .p_rdata(p_rdata),
    .p_fault(p_fault), .p_halt(p_halt)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge: outputs are settled there
  // and inputs driven here are seen by the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; s_req = 1'b0; s_addr = '0; s_w_rb = 1'b0; s_acc = '0;
    s_wdata = '0; p_resp = 1'b0; p_rdata = '0; p_fault = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // ---- reset state ----
    check("rst_ready", s_ready, 1);
    check("rst_halt", p_halt, 1);
    check("rst_preq", p_req, 0);
    check("rst_sresp", s_resp, 0);
    check("rst_serr", s_err, 0);
    check("rst_cause", err_cause, 0);
    check("rst_eaddr", err_addr, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_paddr", p_addr, 0);

    // ---- read, slave answers 3 cycles after p_req ----
    s_req = 1'b1; s_addr = 32'h0000_1000; s_w_rb = 1'b0; s_acc = 2'd2;  // T
    tick(); s_req = 1'b0;                                                // T+1
    check("rd_preq", p_req, 1);
    check("rd_halt_issue", p_halt, 0);
    check("rd_busy", s_ready, 0);
    check("rd_paddr", p_addr, 32'h0000_1000);
    check("rd_pwrb", p_w_rb, 0);
    check("rd_pacc", p_acc, 2);
    tick();                                                              // T+2
    check("rd_preq_once", p_req, 0);
    check("rd_halt_wait", p_halt, 0);
    check("rd_noresp2", s_resp, 0);
    tick();                                                              // T+3
    check("rd_noresp3", s_resp, 0);
    tick(); p_resp = 1'b1; p_rdata = 32'hA5A5_1234;                      // T+4
    check("rd_noresp4", s_resp, 0);
    tick(); p_resp = 1'b0;                                               // T+5
    check("rd_sresp", s_resp, 1);
    check("rd_serr", s_err, 0);
    check("rd_rdata", s_rdata, 32'hA5A5_1234);
    check("rd_idle", s_ready, 1);
    tick();                                                              // T+6
    check("rd_pulse", s_resp, 0);

    // ---- write to unmapped address, decode fault ----
    s_req = 1'b1; s_addr = 32'hDEAD_0000; s_w_rb = 1'b1; s_acc = 2'd3;
    s_wdata = 32'h1234_5678;                                             // T
    tick(); s_req = 1'b0; p_fault = 1'b1;                                // T+1
    check("flt_preq", p_req, 1);
    check("flt_pwrb", p_w_rb, 1);
    check("flt_pwdata", p_wdata, 32'h1234_5678);
    tick(); p_fault = 1'b0;                                              // T+2
    check("flt_sresp", s_resp, 1);
    check("flt_serr", s_err, 1);
    check("flt_cause", err_cause, 2'b01);
    check("flt_eaddr", err_addr, 32'hDEAD_0000);
    check("flt_rdata0", s_rdata, 0);
    tick();
    check("flt_pulse", s_resp, 0);
    check("flt_cause_hold", err_cause, 2'b01);

    // ---- timeout, with s_req while busy and a late p_resp ----
    s_req = 1'b1; s_addr = 32'h0000_2000; s_w_rb = 1'b0; s_acc = 2'd0;  // T
    tick(); s_req = 1'b0;                                                // T+1
    check("to_preq", p_req, 1);
    for (int i = 2; i <= 9; i++) begin
      tick();                                                            // T+i
      if (i == 2) begin
        s_req = 1'b1; s_addr = 32'h0000_3000;
      end else begin
        s_req = 1'b0;
      end
      check($sformatf("to_noresp_%0d", i), s_resp, 0);
      check($sformatf("to_nopreq_%0d", i), p_req, 0);
    end
    tick(); p_resp = 1'b1; p_rdata = 32'hFFFF_0000;                      // T+10
    check("to_sresp", s_resp, 1);
    check("to_serr", s_err, 1);
    check("to_cause", err_cause, 2'b10);
    check("to_eaddr", err_addr, 32'h0000_2000);
    check("to_paddr_hold", p_addr, 32'h0000_2000);
    check("to_halt", p_halt, 1);
    tick(); p_resp = 1'b0;                                               // T+11
    check("late_noresp", s_resp, 0);
    check("late_ready", s_ready, 1);
    check("late_rdata", s_rdata, 0);
    tick();
    check("late_noissue", p_req, 0);

    // ---- p_resp on the cycle the counter reaches TIMEOUT-1 ----
    s_req = 1'b1; s_addr = 32'h0000_4000;                                // T
    tick(); s_req = 1'b0;                                                // T+1
    for (int i = 2; i <= 9; i++) tick();                                 // T+9
    p_resp = 1'b1; p_rdata = 32'hCAFE_F00D;
    tick(); p_resp = 1'b0;                                               // T+10
    check("edge_sresp", s_resp, 1);
    check("edge_serr", s_err, 0);
    check("edge_rdata", s_rdata, 32'hCAFE_F00D);
    check("edge_cause_hold", err_cause, 2'b10);
    check("edge_ready", s_ready, 1);

    // ---- back-to-back: accept s_req in the s_resp cycle, zero-wait slave ----
    s_req = 1'b1; s_addr = 32'h0000_5000;                                // T'
    tick(); s_req = 1'b0; p_resp = 1'b1; p_rdata = 32'h1111_2222;        // T'+1
    check("b2b_preq", p_req, 1);
    check("b2b_paddr", p_addr, 32'h0000_5000);
    check("b2b_noresp", s_resp, 0);
    tick(); p_resp = 1'b0;                                               // T'+2
    check("b2b_sresp", s_resp, 1);
    check("b2b_serr", s_err, 0);
    check("b2b_rdata", s_rdata, 32'h1111_2222);

    // ---- reset asserted in WAIT ----
    s_req = 1'b1; s_addr = 32'h0000_6000;                                // T
    tick(); s_req = 1'b0;                                                // T+1
    tick();                                                              // T+2
    check("rw_inwait", p_halt, 0);
    tick(); rst = 1'b1;                                                  // T+3
    tick(); rst = 1'b0;                                                  // T+4
    check("rw_ready", s_ready, 1);
    check("rw_halt", p_halt, 1);
    check("rw_noresp", s_resp, 0);
    check("rw_paddr", p_addr, 0);
    check("rw_cause", err_cause, 0);
    check("rw_rdata", s_rdata, 0);
    tick(); p_resp = 1'b1; p_rdata = 32'h7777_7777;                      // T+5
    check("rw_noresp5", s_resp, 0);
    tick(); p_resp = 1'b0;                                               // T+6
    check("rw_noresp6", s_resp, 0);
    check("rw_rdata_hold", s_rdata, 0);
    tick();                                                              // T+7
    check("rw_noresp7", s_resp, 0);
    check("rw_idle", s_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
